// File: rtl/l1_cache_pkg.sv
// Shared definitions for the N-way L1 cache controller.
//   l1_state_e   : controller FSM states
//   SRC_*        : data_src encodings (arbiter line vs CPU write data)
//   ADDR_*       : wb_addr_sel encodings (CPU address vs stored tag)
package l1_cache_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOOKUP,
      ST_WB,
      ST_FILL,
      ST_RESP
   } l1_state_e;

   localparam logic SRC_ARB  = 1'b0;
   localparam logic SRC_CPU  = 1'b1;

   localparam logic ADDR_CPU = 1'b0;
   localparam logic ADDR_TAG = 1'b1;

endpackage

// File: rtl/l1_perf_counter.sv
// Saturating performance counter.
//   clk, rst : clock, asynchronous active-high reset
//   inc      : increment request for this cycle
//   count    : current value, holds at all-ones
module l1_perf_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else if (inc && (count_q != {CNT_W{1'b1}})) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign count = count_q;

endmodule

// File: rtl/l1_cache_ctrl_nway.sv
// Control FSM for an N-way set-associative write-back/write-allocate L1.
//   CPU side  : mem_read, mem_write in; mem_resp out
//   Datapath  : hit, hit_way, victim_way, victim_dirty in;
//               sel_way, load_data, data_src, load_tag, load_dirty,
//               dirty_in, load_lru, lru_way, wb_addr_sel out
//   Arbiter   : arb_resp in; arb_read, arb_write out
//   Counters  : hit_count, miss_count, wb_count (saturating)
//
// state  | meaning
// IDLE   | waiting for a CPU request, hit/miss decided here
// WB     | writing back the dirty victim line
// FILL   | fetching the line into the latched victim way
// LOOKUP | one settle cycle after the fill, re-checks hit
// RESP   | completes the CPU access, updates LRU
module l1_cache_ctrl_nway
   import l1_cache_pkg::*;
#(
   parameter int WAYS  = 2,
   parameter int WAY_W = $clog2(WAYS),
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mem_read,
   input  logic             mem_write,
   input  logic             hit,
   input  logic [WAY_W-1:0] hit_way,
   input  logic [WAY_W-1:0] victim_way,
   input  logic             victim_dirty,
   input  logic             arb_resp,
   output logic             mem_resp,
   output logic             arb_read,
   output logic             arb_write,
   output logic             wb_addr_sel,
   output logic [WAY_W-1:0] sel_way,
   output logic             load_data,
   output logic             data_src,
   output logic             load_tag,
   output logic             load_dirty,
   output logic             dirty_in,
   output logic             load_lru,
   output logic [WAY_W-1:0] lru_way,
   output logic [CNT_W-1:0] hit_count,
   output logic [CNT_W-1:0] miss_count,
   output logic [CNT_W-1:0] wb_count
);

   l1_state_e        state_q, state_d;
   logic [WAY_W-1:0] v_way_q, v_way_d;
   logic             hit_inc, miss_inc, wb_inc;
   logic             req;

   assign req = mem_read | mem_write;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         v_way_q <= '0;
      end else begin
         state_q <= state_d;
         v_way_q <= v_way_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      v_way_d     = v_way_q;
      mem_resp    = 1'b0;
      arb_read    = 1'b0;
      arb_write   = 1'b0;
      wb_addr_sel = ADDR_CPU;
      sel_way     = '0;
      load_data   = 1'b0;
      data_src    = SRC_ARB;
      load_tag    = 1'b0;
      load_dirty  = 1'b0;
      dirty_in    = 1'b0;
      load_lru    = 1'b0;
      lru_way     = '0;
      hit_inc     = 1'b0;
      miss_inc    = 1'b0;
      wb_inc      = 1'b0;
      // Outputs are combinational, so reset must force them low explicitly
      // (IDLE alone would still pass hit_way through on sel_way).
      if (!rst) begin
         sel_way = hit_way;
         unique case (state_q)
            ST_IDLE: begin
               if (req) begin
                  if (hit) begin
                     state_d = ST_RESP;
                     hit_inc = 1'b1;
                  end else begin
                     v_way_d  = victim_way;
                     state_d  = victim_dirty ? ST_WB : ST_FILL;
                     miss_inc = 1'b1;
                  end
               end
            end
            ST_WB: begin
               arb_write   = 1'b1;
               wb_addr_sel = ADDR_TAG;
               sel_way     = v_way_q;
               if (arb_resp) begin
                  state_d = ST_FILL;
                  wb_inc  = 1'b1;
               end
            end
            ST_FILL: begin
               arb_read = 1'b1;
               sel_way  = v_way_q;
               data_src = SRC_ARB;
               if (arb_resp) begin
                  load_data  = 1'b1;
                  load_tag   = 1'b1;
                  load_dirty = 1'b1;
                  dirty_in   = 1'b0;
                  state_d    = ST_LOOKUP;
               end
            end
            ST_LOOKUP: begin
               // A miss here (line evicted under us) is retried as a fresh
               // miss but not counted again.
               if (hit) begin
                  state_d = ST_RESP;
               end else begin
                  v_way_d = victim_way;
                  state_d = victim_dirty ? ST_WB : ST_FILL;
               end
            end
            ST_RESP: begin
               mem_resp = 1'b1;
               load_lru = 1'b1;
               lru_way  = hit_way;
               sel_way  = hit_way;
               if (mem_write) begin
                  load_data  = 1'b1;
                  data_src   = SRC_CPU;
                  load_dirty = 1'b1;
                  dirty_in   = 1'b1;
               end
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   l1_perf_counter #(.CNT_W(CNT_W)) u_hit_cnt (
      .clk(clk), .rst(rst), .inc(hit_inc), .count(hit_count)
   );

   l1_perf_counter #(.CNT_W(CNT_W)) u_miss_cnt (
      .clk(clk), .rst(rst), .inc(miss_inc), .count(miss_count)
   );

   l1_perf_counter #(.CNT_W(CNT_W)) u_wb_cnt (
      .clk(clk), .rst(rst), .inc(wb_inc), .count(wb_count)
   );

endmodule

// File: tb/tb_l1_cache_ctrl_nway.sv
module tb_l1_cache_ctrl_nway;

   localparam int WAYS  = 4;
   localparam int WAY_W = 2;
   localparam int CNT_W = 4;
   localparam int CMAX  = 15;

   logic             clk = 1'b0;
   logic             rst;
   logic             mem_read, mem_write, hit, victim_dirty, arb_resp;
   logic [WAY_W-1:0] hit_way, victim_way;
   logic             mem_resp, arb_read, arb_write, wb_addr_sel;
   logic [WAY_W-1:0] sel_way, lru_way;
   logic             load_data, data_src, load_tag, load_dirty, dirty_in, load_lru;
   logic [CNT_W-1:0] hit_count, miss_count, wb_count;

   l1_cache_ctrl_nway #(.WAYS(WAYS), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .mem_read(mem_read), .mem_write(mem_write),
      .hit(hit), .hit_way(hit_way),
      .victim_way(victim_way), .victim_dirty(victim_dirty),
      .arb_resp(arb_resp),
      .mem_resp(mem_resp), .arb_read(arb_read), .arb_write(arb_write),
      .wb_addr_sel(wb_addr_sel), .sel_way(sel_way),
      .load_data(load_data), .data_src(data_src), .load_tag(load_tag),
      .load_dirty(load_dirty), .dirty_in(dirty_in),
      .load_lru(load_lru), .lru_way(lru_way),
      .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       rd, wr, hit;
      logic [1:0] hway, vway;
      logic       vdirty, ar;
   } in_t;

   typedef struct packed {
      logic       mem_resp, arb_read, arb_write, wb_addr_sel;
      logic [1:0] sel_way;
      logic       load_data, data_src, load_tag, load_dirty, dirty_in, load_lru;
      logic [1:0] lru_way;
   } obs_t;

   typedef struct packed {
      in_t  in;
      obs_t exp;
   } step_t;

   int    n_cmp = 0;
   int    n_bad = 0;
   int    m_hit, m_miss, m_wb;
   step_t q[$];
   step_t dir_tab[13];

   function automatic in_t mk_in(logic rd, logic wr, logic h, logic [1:0] hw,
                                 logic [1:0] vw, logic vd, logic ar);
      in_t i;
      i.rd = rd; i.wr = wr; i.hit = h; i.hway = hw;
      i.vway = vw; i.vdirty = vd; i.ar = ar;
      return i;
   endfunction

   function automatic obs_t f_z(logic [1:0] sw);
      obs_t o = '0;
      o.sel_way = sw;
      return o;
   endfunction

   function automatic obs_t f_resp(logic [1:0] w, logic wr);
      obs_t o = f_z(w);
      o.mem_resp = 1'b1; o.load_lru = 1'b1; o.lru_way = w;
      if (wr) begin
         o.load_data = 1'b1; o.data_src = 1'b1; o.load_dirty = 1'b1; o.dirty_in = 1'b1;
      end
      return o;
   endfunction

   function automatic obs_t f_wb(logic [1:0] v);
      obs_t o = f_z(v);
      o.arb_write = 1'b1; o.wb_addr_sel = 1'b1;
      return o;
   endfunction

   function automatic obs_t f_fill(logic [1:0] v, logic done);
      obs_t o = f_z(v);
      o.arb_read = 1'b1;
      if (done) begin
         o.load_data = 1'b1; o.load_tag = 1'b1; o.load_dirty = 1'b1;
      end
      return o;
   endfunction

   function automatic int sat(int x);
      return (x > CMAX) ? CMAX : x;
   endfunction

   function automatic obs_t get_obs();
      obs_t o;
      o.mem_resp = mem_resp; o.arb_read = arb_read; o.arb_write = arb_write;
      o.wb_addr_sel = wb_addr_sel; o.sel_way = sel_way; o.load_data = load_data;
      o.data_src = data_src; o.load_tag = load_tag; o.load_dirty = load_dirty;
      o.dirty_in = dirty_in; o.load_lru = load_lru; o.lru_way = lru_way;
      return o;
   endfunction

   task automatic drive(input in_t i);
      mem_read = i.rd; mem_write = i.wr; hit = i.hit; hit_way = i.hway;
      victim_way = i.vway; victim_dirty = i.vdirty; arb_resp = i.ar;
   endtask

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic run_step(input step_t s, input string nm);
      drive(s.in);
      @(negedge clk);
      check(nm, 64'(get_obs()), 64'(s.exp));
      @(posedge clk);
      #1;
   endtask

   task automatic run_q(input string nm);
      int k = 0;
      while (q.size() > 0) begin
         run_step(q.pop_front(), $sformatf("%s[%0d]", nm, k));
         k++;
      end
   endtask

   task automatic check_cnt(input string nm);
      check({nm, "_hit_count"},  64'(hit_count),  64'(sat(m_hit)));
      check({nm, "_miss_count"}, 64'(miss_count), 64'(sat(m_miss)));
      check({nm, "_wb_count"},   64'(wb_count),   64'(sat(m_wb)));
   endtask

   // Transaction-level expectation: the cycle sequence one CPU access must
   // produce, derived from the hit/miss/dirty outcome and arbiter latencies.
   task automatic build_txn(input logic rd, input logic wr, input logic hf,
                            input logic [1:0] hw, input logic dirty,
                            input logic [1:0] vic, input int wbl, input int fl,
                            input logic vchg);
      in_t i;
      i = mk_in(rd, wr, hf, hf ? hw : 2'($urandom), vic, dirty, 1'($urandom));
      q.push_back({i, f_z(i.hway)});
      if (hf) begin
         i = mk_in(rd, wr, 1'b1, hw, 2'($urandom), 1'($urandom), 1'($urandom));
         q.push_back({i, f_resp(hw, wr)});
         m_hit++;
      end else begin
         m_miss++;
         if (dirty) begin
            for (int k = 1; k <= wbl; k++) begin
               i = mk_in(rd, wr, 1'($urandom), 2'($urandom),
                         vchg ? 2'($urandom) : vic, 1'($urandom), k == wbl);
               q.push_back({i, f_wb(vic)});
            end
            m_wb++;
         end
         for (int k = 1; k <= fl; k++) begin
            i = mk_in(rd, wr, 1'($urandom), 2'($urandom),
                      vchg ? 2'($urandom) : vic, 1'($urandom), k == fl);
            q.push_back({i, f_fill(vic, k == fl)});
         end
         i = mk_in(rd, wr, 1'b1, vic, 2'($urandom), 1'($urandom), 1'($urandom));
         q.push_back({i, f_z(vic)});
         i = mk_in(rd, wr, 1'b1, vic, 2'($urandom), 1'($urandom), 1'($urandom));
         q.push_back({i, f_resp(vic, wr)});
      end
   endtask

   task automatic add_gap(input int n);
      in_t i;
      for (int k = 0; k < n; k++) begin
         i = mk_in(1'b0, 1'b0, 1'($urandom), 2'($urandom), 2'($urandom),
                   1'($urandom), 1'($urandom));
         q.push_back({i, f_z(i.hway)});
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #3;
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_hit = 0; m_miss = 0; m_wb = 0;
   endtask

   initial begin
      // read hit way 2, write hit way 1 (rd+wr = write), then a fill whose
      // LOOKUP misses and is retried through a dirty writeback to way 1
      dir_tab[0]  = {mk_in(1,0,1,2'd2,2'd0,0,0), f_z(2'd2)};
      dir_tab[1]  = {mk_in(1,0,1,2'd2,2'd0,0,0), f_resp(2'd2, 1'b0)};
      dir_tab[2]  = {mk_in(1,1,1,2'd1,2'd3,1,0), f_z(2'd1)};
      dir_tab[3]  = {mk_in(1,1,1,2'd1,2'd3,1,0), f_resp(2'd1, 1'b1)};
      dir_tab[4]  = {mk_in(0,0,0,2'd3,2'd0,0,1), f_z(2'd3)};
      dir_tab[5]  = {mk_in(1,0,0,2'd0,2'd2,0,0), f_z(2'd0)};
      dir_tab[6]  = {mk_in(1,0,0,2'd0,2'd1,1,1), f_fill(2'd2, 1'b1)};
      dir_tab[7]  = {mk_in(1,0,0,2'd3,2'd1,1,0), f_z(2'd3)};
      dir_tab[8]  = {mk_in(1,0,1,2'd2,2'd3,0,1), f_wb(2'd1)};
      dir_tab[9]  = {mk_in(1,0,0,2'd0,2'd3,0,1), f_fill(2'd1, 1'b1)};
      dir_tab[10] = {mk_in(1,0,1,2'd1,2'd0,0,0), f_z(2'd1)};
      dir_tab[11] = {mk_in(1,0,1,2'd1,2'd0,0,0), f_resp(2'd1, 1'b0)};
      dir_tab[12] = {mk_in(0,0,0,2'd0,2'd0,0,0), f_z(2'd0)};

      // reset state: every output low even with hit_way nonzero
      rst = 1'b1;
      drive(mk_in(1, 1, 1, 2'd3, 2'd2, 1, 1));
      #12;
      check("rst_outputs", 64'(get_obs()), 64'(0));
      m_hit = 0; m_miss = 0; m_wb = 0;
      check_cnt("rst");
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int n = 0; n < 13; n++) run_step(dir_tab[n], $sformatf("dir[%0d]", n));
      m_hit = 2; m_miss = 1; m_wb = 1;
      check_cnt("dir");

      // clean read miss, victim 3, arb_resp on 5th FILL cycle
      build_txn(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd3, 0, 5, 1'b0);
      run_q("clean_miss");
      check_cnt("clean_miss");
      // dirty write miss, victim 0, victim_way wandering during WB/FILL
      build_txn(1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 2'd0, 3, 2, 1'b1);
      run_q("dirty_miss");
      check_cnt("dirty_miss");

      for (int t = 0; t < 150; t++) begin
         logic wr, rd, hf;
         wr = 1'($urandom);
         rd = wr ? 1'($urandom) : 1'b1;
         hf = ($urandom_range(0, 2) == 0);
         build_txn(rd, wr, hf, 2'($urandom), 1'($urandom), 2'($urandom),
                   $urandom_range(1, 6), $urandom_range(1, 6), 1'($urandom));
         add_gap($urandom_range(0, 2));
         run_q($sformatf("rand%0d", t));
         check_cnt($sformatf("rand%0d", t));
      end

      // reset asserted mid-FILL drops arb_read immediately
      do_reset();
      drive(mk_in(1, 0, 0, 2'd1, 2'd2, 0, 0));
      @(posedge clk);
      #1;
      drive(mk_in(1, 0, 0, 2'd1, 2'd2, 0, 0));
      check("fill_arb_read", 64'(arb_read), 64'(1));
      #2;
      rst = 1'b1;
      #1;
      check("rst_fill_outputs", 64'(get_obs()), 64'(0));
      m_hit = 0; m_miss = 0; m_wb = 0;
      check_cnt("rst_fill");
      @(posedge clk);
      #1;
      rst = 1'b0;
      build_txn(1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 2'd0, 0, 0, 1'b0);
      run_q("post_rst_hit");
      check_cnt("post_rst_hit");

      // 20 hits saturate a 4-bit counter at 15
      do_reset();
      for (int t = 0; t < 20; t++) begin
         build_txn(1'b1, 1'b0, 1'b1, 2'($urandom), 1'b0, 2'd0, 0, 0, 1'b0);
      end
      run_q("sat");
      check("sat_hit_count", 64'(hit_count), 64'(15));
      check_cnt("sat");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
